// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl_if : request/response handshake and memory bus bundle
// Rev 1.0
// ============================================================================
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8,
   parameter int ERR_W  = 4
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic              req_verify;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ERR_W-1:0]  err_cnt;
   logic [ADDR_W-1:0] mem_add;
   logic              mem_rw;
   logic [DATA_W-1:0] mem_i;
   logic [DATA_W-1:0] mem_s;

   // Controller view: owns the memory bus and the response channel.
   modport master (
      input  req_valid, req_write, req_verify, req_addr, req_wdata,
      input  rsp_ready, mem_s,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
      output mem_add, mem_rw, mem_i
   );

   modport slave (
      output req_valid, req_write, req_verify, req_addr, req_wdata,
      output rsp_ready, mem_s,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt,
      input  mem_add, mem_rw, mem_i
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : single-outstanding read/write/verify controller for a
//                   small register-file memory. Rev 1.0
// ============================================================================
module mem_access_ctrl #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8,
   parameter int ERR_W  = 4
) (
   input  wire logic         clk,
   input  wire logic         reset,
   mem_access_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_VFY  = 3'd3,
      ST_RSP  = 3'd4
   } state_t;

   state_t            state_q,     state_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;
   logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;
   logic [ADDR_W-1:0] mem_add_q,   mem_add_d;
   logic              mem_rw_q,    mem_rw_d;
   logic [DATA_W-1:0] mem_i_q,     mem_i_d;
   logic              verify_q,    verify_d;
   logic              mismatch;

   // mem_i_q doubles as the latched write data used by the verify compare.
   assign mismatch = (bus.mem_s != mem_i_q);

   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      err_cnt_d   = err_cnt_q;
      mem_add_d   = mem_add_q;
      mem_rw_d    = 1'b0;
      mem_i_d     = mem_i_q;
      verify_d    = verify_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               mem_add_d   = bus.req_addr;
               mem_i_d     = bus.req_wdata;
               verify_d    = bus.req_verify & bus.req_write;
               req_ready_d = 1'b0;
               if (bus.req_write) begin
                  mem_rw_d = 1'b1;
                  state_d  = ST_WR;
               end else begin
                  state_d  = ST_RD;
               end
            end
         end
         ST_WR: begin
            if (verify_q) begin
               state_d = ST_VFY;
            end else begin
               rsp_rdata_d = mem_i_q;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = ST_RSP;
            end
         end
         ST_RD: begin
            rsp_rdata_d = bus.mem_s;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RSP;
         end
         ST_VFY: begin
            rsp_rdata_d = bus.mem_s;
            rsp_err_d   = mismatch;
            if (mismatch && (err_cnt_q != {ERR_W{1'b1}}))
               err_cnt_d = err_cnt_q + ERR_W'(1);
            rsp_valid_d = 1'b1;
            state_d     = ST_RSP;
         end
         ST_RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         err_cnt_q   <= '0;
         mem_add_q   <= '0;
         mem_rw_q    <= 1'b0;
         mem_i_q     <= '0;
         verify_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         err_cnt_q   <= err_cnt_d;
         mem_add_q   <= mem_add_d;
         mem_rw_q    <= mem_rw_d;
         mem_i_q     <= mem_i_d;
         verify_q    <= verify_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.mem_add   = mem_add_q;
   assign bus.mem_rw    = mem_rw_q;
   assign bus.mem_i     = mem_i_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_access_ctrl : directed vector bench with a 4x8 memory model
// Rev 1.0
// ============================================================================
module tb_mem_access_ctrl;

   logic clk;
   logic reset;
   logic stuck;
   int   checks;
   int   failures;
   logic [7:0] mem_model [4] = '{default: 8'h00};

   mem_access_ctrl_if #(.ADDR_W(2), .DATA_W(8), .ERR_W(4)) bus ();

   mem_access_ctrl #(.ADDR_W(2), .DATA_W(8), .ERR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: bit0 of word 0 reads back as 0 while stuck is set.
   always @(posedge clk) begin
      if (bus.mem_rw) mem_model[bus.mem_add] <= bus.mem_i;
   end
   assign bus.mem_s = (stuck && bus.mem_add == 2'd0) ? (mem_model[0] & 8'hFE)
                                                    : mem_model[bus.mem_add];

   typedef struct {
      logic       wr;
      logic       vf;
      logic       stk;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
      int         exp_lat;
      logic [3:0] exp_cnt;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_req(input logic wr, input logic vf, input logic [1:0] a,
                         input logic [7:0] d, output logic [7:0] rd,
                         output logic er, output int lat, output int rw_cyc,
                         output logic addr_ok);
      int   w;
      logic got;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_verify = vf;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.rsp_ready  = 1'b1;
      w = 0;
      while (!bus.req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) check("req_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_wdata = ~d;
      bus.req_addr  = ~a;
      rw_cyc  = 0;
      addr_ok = 1'b1;
      got     = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.mem_rw) begin
            rw_cyc++;
            if (bus.mem_add != a) addr_ok = 1'b0;
         end
         if (bus.rsp_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!got) lat = -1;
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] rd;
      logic       er;
      int         lat;
      int         rwc;
      logic       aok;

      checks   = 0;
      failures = 0;
      stuck    = 1'b0;
      reset    = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_verify = 1'b0;
      bus.req_addr   = 2'd0;
      bus.req_wdata  = 8'h00;
      bus.rsp_ready  = 1'b1;

      //          wr    vf    stk   addr  wdata  rdata  err   lat cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 8'h25, 8'h25, 1'b0, 2, 4'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'd1, 8'h00, 8'h25, 1'b0, 2, 4'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd2, 8'hFF, 8'hFF, 1'b0, 2, 4'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd3, 8'h57, 8'h57, 1'b0, 2, 4'd0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 2, 4'd0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h00, 8'hFF, 1'b0, 2, 4'd0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd3, 8'h00, 8'h57, 1'b0, 2, 4'd0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd2, 8'h3C, 8'h3C, 1'b0, 3, 4'd0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 8'h3C, 1'b0, 2, 4'd0};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h07, 8'h06, 1'b1, 3, 4'd1};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'hA5, 8'hA5, 1'b0, 2, 4'd1};

      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
      check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
      check("rst_err_cnt",   {28'd0, bus.err_cnt},   32'd0);
      check("rst_mem_add",   {30'd0, bus.mem_add},   32'd0);
      check("rst_mem_rw",    {31'd0, bus.mem_rw},    32'd0);
      check("rst_mem_i",     {24'd0, bus.mem_i},     32'd0);
      reset = 1'b1;

      for (int v = 0; v < 11; v++) begin
         stuck = vecs[v].stk;
         do_req(vecs[v].wr, vecs[v].vf, vecs[v].addr, vecs[v].wdata, rd, er, lat, rwc, aok);
         check($sformatf("v%0d_rdata", v), {24'd0, rd}, {24'd0, vecs[v].exp_rdata});
         check($sformatf("v%0d_err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
         check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
         check($sformatf("v%0d_rw_cycles", v), rwc, vecs[v].wr ? 1 : 0);
         check($sformatf("v%0d_rw_addr", v), {31'd0, aok}, 32'd1);
         check($sformatf("v%0d_err_cnt", v), {28'd0, bus.err_cnt}, {28'd0, vecs[v].exp_cnt});
         check($sformatf("v%0d_idle_ready", v), {31'd0, bus.req_ready}, 32'd1);
      end

      // Saturation: 19 more mismatching verified writes take err_cnt 1 -> 15.
      stuck = 1'b1;
      for (int n = 0; n < 19; n++) begin
         do_req(1'b1, 1'b1, 2'd0, 8'h07, rd, er, lat, rwc, aok);
         if (n == 13) check("err_cnt_at_15", {28'd0, bus.err_cnt}, 32'd15);
      end
      check("sat_err_cnt", {28'd0, bus.err_cnt}, 32'd15);
      check("sat_rsp_err", {31'd0, er}, 32'd1);
      check("sat_rdata",   {24'd0, rd}, 32'h06);

      // Backpressure on a read of 8'hA5 (addr 1), stray request during the stall.
      @(negedge clk);
      bus.rsp_ready  = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_verify = 1'b0;
      bus.req_addr   = 2'd1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
         check("bp_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'hA5);
         check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
         check("bp_mem_rw",    {31'd0, bus.mem_rw},    32'd0);
         bus.req_valid = (c == 1);
         bus.req_write = 1'b1;
         bus.req_addr  = 2'd0;
         bus.req_wdata = 8'h11;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("bp_done_ready", {31'd0, bus.req_ready}, 32'd1);
      check("bp_stray_ignored", {24'd0, mem_model[0]}, 32'h07);

      // Asynchronous reset while a response is stalled.
      bus.rsp_ready  = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_addr   = 2'd2;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("arst_mem_rw",    {31'd0, bus.mem_rw},    32'd0);
      check("arst_err_cnt",   {28'd0, bus.err_cnt},   32'd0);
      @(negedge clk);
      reset = 1'b1;
      bus.rsp_ready = 1'b1;

      // Reset during WR: the write to addr 3 must not commit.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 2'd3;
      bus.req_wdata = 8'h99;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("wr_mem_rw_high", {31'd0, bus.mem_rw}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("wr_rst_mem_rw", {31'd0, bus.mem_rw}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("wr_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
         check("wr_rst_idle",   {31'd0, bus.req_ready}, 32'd1);
      end
      check("wr_rst_mem_kept", {24'd0, mem_model[3]}, 32'h57);
      do_req(1'b0, 1'b0, 2'd3, 8'h00, rd, er, lat, rwc, aok);
      check("wr_rst_readback", {24'd0, rd}, 32'h57);
      check("wr_rst_read_lat", lat, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
